// File: rtl/stdin_uart_rx.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO for the CPU stdin port.
// Framing errors and overruns are reported on sticky flags cleared by err_clear.
module stdin_uart_rx #(
  parameter int BAUD      = 104,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [7:0]           stdin_data,
  output logic                 stdin_valid,
  input  logic                 stdin_ready,
  output logic [CNT_WIDTH-1:0] level,
  output logic                 framing_err,
  output logic                 overrun,
  input  logic                 err_clear,
  output logic [2:0]           rx_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BAUD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_meta, rxs;
  logic [AW:0]     wr_ptr, rd_ptr, wr_n, rd_n;
  logic [7:0]      mem [DEPTH];
  logic            tick, byte_done, full, push, pop;

  assign rx_state  = state;
  assign tick      = (timer == '0);
  assign byte_done = (state == STOP) && tick && rxs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Bit timer starts at half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      framing_err <= 1'b0;
    end else begin
      if ((state == STOP) && tick && !rxs) framing_err <= 1'b1;
      else if (err_clear)                  framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            timer <= TW'(BAUD / 2 - 1);
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rxs) begin
              timer   <= TW'(BAUD - 1);
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rxs;
            timer          <= TW'(BAUD - 1);
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (tick) state <= rxs ? IDLE : BREAK;
          else      timer <= timer - 1'b1;
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: the head byte transfers on any edge where stdin_valid && stdin_ready;
  // stdin_valid never depends on stdin_ready, and ready while empty does nothing.
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign stdin_valid = (wr_ptr != rd_ptr);
  assign pop         = stdin_valid && stdin_ready;
  assign push        = byte_done && (!full || pop);
  assign wr_n        = wr_ptr + {{AW{1'b0}}, push};
  assign rd_n        = rd_ptr + {{AW{1'b0}}, pop};
  assign stdin_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= shreg;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      level  <= CNT_WIDTH'(wr_n - rd_n);
      if (byte_done && full && !pop) overrun <= 1'b1;
      else if (err_clear)            overrun <= 1'b0;
    end
  end
endmodule
